riscv_next_strategy_btb_ctrl: RTL and testbench

//   Learning controller for the next-PC injection strategy of the jump predictor.

---
 rtl/riscv_next_strategy_btb_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_riscv_next_strategy_btb_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_next_strategy_btb_ctrl.sv
// riscv_next_strategy_btb_ctrl
//   Learning next-PC injection controller: a small fully-associative table of
//   (branch PC -> target) pairs with saturating confidence counters. Fetch looks
//   the table up combinationally; execute-stage outcomes allocate, train and
//   evict entries.
//
//   Optional feature macro: JP_HARDCODED_SEED_EN
//     Defined: entry 0 is a locked seed entry (pc = HARDCODED_FROM, target =
//     HARDCODED_TO, defaulting to 20 / 44) that is never trained, flushed or
//     evicted; allocation and the victim pointer use entries 1..ENTRIES-1.
//     Undefined: every entry is dynamic.
`ifndef HARDCODED_FROM
`define HARDCODED_FROM 20
`endif
`ifndef HARDCODED_TO
`define HARDCODED_TO 44
`endif
module riscv_next_strategy_btb_ctrl #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned ENTRIES    = 4,
  parameter int unsigned CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  enable,
  input  logic                  i_stall,
  input  logic [ADDR_WIDTH-1:0] i_pm_pc,
  output logic                  o_inject,
  output logic [ADDR_WIDTH-1:0] o_inject_addr,
  input  logic                  i_upd_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_pc,
  input  logic [ADDR_WIDTH-1:0] i_upd_target,
  input  logic                  i_upd_taken,
  input  logic                  i_flush
);

  localparam int unsigned PtrW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

`ifdef JP_HARDCODED_SEED_EN
  localparam int unsigned FirstDyn = 1;
  localparam logic [ADDR_WIDTH-1:0] SeedPc  = ADDR_WIDTH'(`HARDCODED_FROM);
  localparam logic [ADDR_WIDTH-1:0] SeedTgt = ADDR_WIDTH'(`HARDCODED_TO);
`else
  localparam int unsigned FirstDyn = 0;
`endif

  localparam logic [PtrW-1:0]      PtrRst  = PtrW'(FirstDyn);
  localparam logic [PtrW-1:0]      PtrLast = PtrW'(ENTRIES - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax  = '1;
  localparam logic [CNT_WIDTH-1:0] CntInit = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

  logic                  valid_q [ENTRIES];
  logic                  valid_d [ENTRIES];
  logic [ADDR_WIDTH-1:0] pc_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] pc_d    [ENTRIES];
  logic [ADDR_WIDTH-1:0] tgt_q   [ENTRIES];
  logic [ADDR_WIDTH-1:0] tgt_d   [ENTRIES];
  logic [CNT_WIDTH-1:0]  cnt_q   [ENTRIES];
  logic [CNT_WIDTH-1:0]  cnt_d   [ENTRIES];
  logic [PtrW-1:0]       ptr_q, ptr_d;

  logic                  lk_hit;
  logic [ADDR_WIDTH-1:0] lk_addr;
  logic                  upd_hit;
  logic [PtrW-1:0]       upd_idx;
  logic                  upd_locked;
  logic                  free_found;
  logic [PtrW-1:0]       free_idx;
  logic [PtrW-1:0]       alloc_idx;

  // Fetch lookup on pre-update state; descending scan so the lowest index wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_addr = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (valid_q[i] && (pc_q[i] == i_pm_pc) && cnt_q[i][CNT_WIDTH-1]) begin
        lk_hit  = 1'b1;
        lk_addr = tgt_q[i];
      end
    end
  end

  // Inject only when enabled; address is zeroed otherwise.
  always_comb begin
    o_inject      = enable & lk_hit;
    o_inject_addr = o_inject ? lk_addr : '0;
  end

  // Update-side match (any confidence) and lowest free dynamic slot.
  always_comb begin
    upd_hit    = 1'b0;
    upd_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (valid_q[i] && (pc_q[i] == i_upd_pc)) begin
        upd_hit = 1'b1;
        upd_idx = PtrW'(i);
      end
    end
    for (int i = int'(ENTRIES) - 1; i >= int'(FirstDyn); i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = PtrW'(i);
      end
    end
  end

  // A hit on the seed entry must leave it untouched.
`ifdef JP_HARDCODED_SEED_EN
  assign upd_locked = upd_hit && (upd_idx == '0);
`else
  assign upd_locked = 1'b0;
`endif

  // Next-state: flush beats update; nothing moves while stalled or disabled.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    alloc_idx = free_found ? free_idx : ptr_q;
    if (enable && !i_stall) begin
      if (i_flush) begin
        for (int i = int'(FirstDyn); i < int'(ENTRIES); i++) begin
          valid_d[i] = 1'b0;
          cnt_d[i]   = '0;
        end
        ptr_d = PtrRst;
      end else if (i_upd_valid) begin
        if (upd_hit) begin
          if (!upd_locked) begin
            if (i_upd_taken) begin
              if (cnt_q[upd_idx] != CntMax) begin
                cnt_d[upd_idx] = cnt_q[upd_idx] + CntOne;
              end
              tgt_d[upd_idx] = i_upd_target;
            end else if (cnt_q[upd_idx] <= CntOne) begin
              // Confidence exhausted: drop the entry.
              cnt_d[upd_idx]   = '0;
              valid_d[upd_idx] = 1'b0;
            end else begin
              cnt_d[upd_idx] = cnt_q[upd_idx] - CntOne;
            end
          end
        end else if (i_upd_taken) begin
          // Victim pointer advances only when an eviction is needed.
          if (!free_found) begin
            ptr_d = (ptr_q == PtrLast) ? PtrRst : ptr_q + 1'b1;
          end
          valid_d[alloc_idx] = 1'b1;
          pc_d[alloc_idx]    = i_upd_pc;
          tgt_d[alloc_idx]   = i_upd_target;
          cnt_d[alloc_idx]   = CntInit;
        end
      end
    end
  end

  // Table and victim pointer registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        pc_q[i]    <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
`ifdef JP_HARDCODED_SEED_EN
      valid_q[0] <= 1'b1;
      pc_q[0]    <= SeedPc;
      tgt_q[0]   <= SeedTgt;
      cnt_q[0]   <= CntMax;
`endif
      ptr_q <= PtrRst;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_riscv_next_strategy_btb_ctrl.sv
// Self-checking bench for riscv_next_strategy_btb_ctrl: directed scenarios
// followed by randomized traffic, all checked against a behavioural table model.
module tb_riscv_next_strategy_btb_ctrl;

  localparam int unsigned AW   = 64;
  localparam int unsigned N    = 4;
  localparam int unsigned CW   = 2;
  localparam int          Half = 1 << (CW - 1);
  localparam int          Max  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          nreset;
  logic          enable;
  logic          i_stall;
  logic [AW-1:0] i_pm_pc;
  logic          o_inject;
  logic [AW-1:0] o_inject_addr;
  logic          i_upd_valid;
  logic [AW-1:0] i_upd_pc;
  logic [AW-1:0] i_upd_target;
  logic          i_upd_taken;
  logic          i_flush;

  always #5 clk = ~clk;

  riscv_next_strategy_btb_ctrl #(
    .ADDR_WIDTH(AW),
    .ENTRIES   (N),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .nreset       (nreset),
    .enable       (enable),
    .i_stall      (i_stall),
    .i_pm_pc      (i_pm_pc),
    .o_inject     (o_inject),
    .o_inject_addr(o_inject_addr),
    .i_upd_valid  (i_upd_valid),
    .i_upd_pc     (i_upd_pc),
    .i_upd_target (i_upd_target),
    .i_upd_taken  (i_upd_taken),
    .i_flush      (i_flush)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: list of entries with integer confidence.
  typedef struct {
    bit          v;
    logic [AW-1:0] pc;
    logic [AW-1:0] tgt;
    int          cnt;
  } ent_t;

  ent_t m_tab [N];
  int   m_ptr;
`ifdef JP_HARDCODED_SEED_EN
  localparam int FirstDyn = 1;
`else
  localparam int FirstDyn = 0;
`endif

  task automatic m_reset();
    for (int i = 0; i < int'(N); i++) m_tab[i] = '{v: 1'b0, pc: '0, tgt: '0, cnt: 0};
`ifdef JP_HARDCODED_SEED_EN
    m_tab[0] = '{v: 1'b1, pc: 64'd20, tgt: 64'd44, cnt: Max};
`endif
    m_ptr = FirstDyn;
  endtask

  task automatic m_lookup(input logic [AW-1:0] pc, output bit hit, output logic [AW-1:0] addr);
    hit  = 1'b0;
    addr = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!hit && m_tab[i].v && m_tab[i].pc == pc && m_tab[i].cnt >= Half) begin
        hit  = 1'b1;
        addr = m_tab[i].tgt;
      end
    end
  endtask

  task automatic m_update(input bit en, input bit st, input bit uv, input logic [AW-1:0] pc,
                          input logic [AW-1:0] tgt, input bit tk, input bit fl);
    int idx;
    if (!en || st) return;
    if (fl) begin
      for (int i = FirstDyn; i < int'(N); i++) m_tab[i].v = 1'b0;
      m_ptr = FirstDyn;
      return;
    end
    if (!uv) return;
    idx = -1;
    for (int i = 0; i < int'(N); i++)
      if (idx < 0 && m_tab[i].v && m_tab[i].pc == pc) idx = i;
    if (idx >= 0) begin
      if (idx < FirstDyn) return;
      if (tk) begin
        m_tab[idx].cnt = (m_tab[idx].cnt < Max) ? m_tab[idx].cnt + 1 : Max;
        m_tab[idx].tgt = tgt;
      end else begin
        m_tab[idx].cnt = m_tab[idx].cnt - 1;
        if (m_tab[idx].cnt <= 0) begin
          m_tab[idx].cnt = 0;
          m_tab[idx].v   = 1'b0;
        end
      end
    end else if (tk) begin
      for (int i = FirstDyn; i < int'(N); i++)
        if (idx < 0 && !m_tab[i].v) idx = i;
      if (idx < 0) begin
        idx   = m_ptr;
        m_ptr = m_ptr + 1;
        if (m_ptr == int'(N)) m_ptr = FirstDyn;
      end
      m_tab[idx] = '{v: 1'b1, pc: pc, tgt: tgt, cnt: Half};
    end
  endtask

  // One cycle: drive after negedge, check outputs vs pre-update model, clock, update model.
  task automatic cyc(input string tag, input bit en, input bit st, input logic [AW-1:0] pm,
                     input bit uv, input logic [AW-1:0] up, input logic [AW-1:0] ut,
                     input bit tk, input bit fl);
    bit            hit;
    logic [AW-1:0] addr;
    @(negedge clk);
    enable       = en;
    i_stall      = st;
    i_pm_pc      = pm;
    i_upd_valid  = uv;
    i_upd_pc     = up;
    i_upd_target = ut;
    i_upd_taken  = tk;
    i_flush      = fl;
    #1;
    m_lookup(pm, hit, addr);
    check_eq({tag, ".inj"}, AW'(o_inject), AW'(en & hit));
    check_eq({tag, ".addr"}, o_inject_addr, (en & hit) ? addr : '0);
    @(posedge clk);
    m_update(en, st, uv, up, ut, tk, fl);
  endtask

  task automatic look(input string tag, input logic [AW-1:0] pm);
    cyc(tag, 1'b1, 1'b0, pm, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic upd(input string tag, input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                     input bit tk);
    cyc(tag, 1'b1, 1'b0, pc, 1'b1, pc, tgt, tk, 1'b0);
  endtask

  task automatic apply_reset(input logic [AW-1:0] pm);
    @(negedge clk);
    nreset  = 1'b0;
    enable  = 1'b1;
    i_pm_pc = pm;
    #1;
    check_eq("rst.inj", AW'(o_inject), '0);
    check_eq("rst.addr", o_inject_addr, '0);
    m_reset();
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] pcs [8];
    nreset = 1'b1; enable = 1'b1; i_stall = 1'b0; i_pm_pc = '0;
    i_upd_valid = 1'b0; i_upd_pc = '0; i_upd_target = '0; i_upd_taken = 1'b0; i_flush = 1'b0;
    m_reset();
    apply_reset(64'h100);
    look("t1", 64'h100);

`ifndef JP_HARDCODED_SEED_EN
    // Allocation, same-cycle invisibility, next-cycle hit.
    upd("t2.alloc", 64'h100, 64'h200, 1'b1);
    look("t2.hit", 64'h100);
    check_eq("t2.const_inj", AW'(o_inject), AW'(1));
    check_eq("t2.const_addr", o_inject_addr, 64'h200);
    // Train down to weakly-not-taken, then invalid, then reallocate.
    upd("t3.nt1", 64'h100, 64'h200, 1'b0);
    look("t3.cnt1", 64'h100);
    check_eq("t3.const_miss", AW'(o_inject), '0);
    upd("t3.nt2", 64'h100, 64'h200, 1'b0);
    upd("t3.realloc", 64'h100, 64'h300, 1'b1);
    look("t3.hit", 64'h100);
    check_eq("t3.const_addr", o_inject_addr, 64'h300);
    apply_reset('0);
    // Round-robin eviction.
    for (int i = 1; i <= 6; i++) upd("t4.fill", AW'(i * 16), AW'(i * 16 + 64'h1000), 1'b1);
    look("t4.ev1", 64'h10);
    check_eq("t4.const_ev1", AW'(o_inject), '0);
    look("t4.ev2", 64'h20);
    look("t4.keep", 64'h30);
    check_eq("t4.const_keep", o_inject_addr, 64'h1030);
    look("t4.new", 64'h60);
`else
    look("t6.seed", 64'd20);
    check_eq("t6.const_seed", o_inject_addr, 64'd44);
    upd("t6.nt", 64'd20, 64'd0, 1'b0);
    look("t6.keep", 64'd20);
    for (int i = 1; i <= 4; i++) upd("t6.fill", AW'(i * 16), AW'(i * 16 + 64'h1000), 1'b1);
    look("t6.ev", 64'h10);
    look("t6.seed2", 64'd20);
`endif

    // Stall blocks update; flush beats a same-cycle update; enable=0 holds table.
    cyc("t5.stall", 1'b1, 1'b1, 64'h700, 1'b1, 64'h700, 64'h7700, 1'b1, 1'b0);
    look("t5.stall_chk", 64'h700);
    upd("t5.pre", 64'h800, 64'h8800, 1'b1);
    cyc("t5.dis", 1'b0, 1'b0, 64'h800, 1'b1, 64'h800, 64'h9900, 1'b0, 1'b1);
    look("t5.kept", 64'h800);
    cyc("t5.flush", 1'b1, 1'b0, 64'h800, 1'b1, 64'h900, 64'h9900, 1'b1, 1'b1);
    look("t5.fl800", 64'h800);
    look("t5.fl900", 64'h900);

    // Randomized traffic over a small PC set so entries collide and train.
    for (int i = 0; i < 8; i++) pcs[i] = AW'((i + 1) * 64'h40);
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset(pcs[$urandom_range(0, 7)]);
      end else begin
        cyc("rnd",
            $urandom_range(0, 15) != 0,
            $urandom_range(0, 9) == 0,
            pcs[$urandom_range(0, 7)],
            $urandom_range(0, 1) == 1,
            pcs[$urandom_range(0, 7)],
            {$urandom, $urandom},
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
